bcd_serial_subtractor: RTL

Multi-digit packed-BCD subtractor, digit-serial: computes A − B − bin one decimal digit per clock, least significant digit first, and returns the difference as BCD magnitude plus sign. A start/busy/done handshake sequences the operation. It is the inverse companion of the team's combinational BCD adder, used where decimal quantities must be decremented or compared, and where a sign-magnitude decimal result is required.

---
 rtl/bcd_serial_subtractor.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor
//
// Digit-serial packed-BCD subtractor. Computes A - B - bin one decimal digit
// per clock, least significant digit first, and returns a sign-magnitude
// result. If the first pass ends with a borrow, the raw result is the tens
// complement, and a second pass (0 - r - br) converts it to the magnitude.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results from the last operation are held
// SUB   | one digit of a - b - br per clock
// NEG   | one digit of 0 - r - br per clock (tens complement -> magnitude)
// DONE  | publish diff/neg/err and pulse done
//
// Ports
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset
//   start_i  operation request, accepted only in IDLE
//   a_i      minuend, packed BCD (digit i = a_i[4i+3:4i])
//   b_i      subtrahend, packed BCD
//   bin_i    borrow-in, subtracted at digit 0
//   busy_o   high while SUB or NEG runs
//   done_o   one-cycle pulse, result valid
//   diff_o   result magnitude, packed BCD
//   neg_o    result is negative
//   err_o    an operand digit was > 9
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   a_i,
    input  logic [4*DIGITS-1:0]   b_i,
    input  logic                  bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   diff_o,
    output logic                  neg_o,
    output logic                  err_o
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SUB, ST_NEG, ST_DONE} state_t;

    state_t                state_q;
    logic [4*DIGITS-1:0]   a_q;
    logic [4*DIGITS-1:0]   b_q;
    logic [4*DIGITS-1:0]   res_q;
    logic [IW-1:0]         idx_q;
    logic                  br_q;
    logic                  neg_pend_q;
    logic                  err_pend_q;
    logic                  busy_q;
    logic                  done_q;
    logic [4*DIGITS-1:0]   diff_q;
    logic                  neg_q;
    logic                  err_q;

    int                    pos;
    logic [3:0]            m_dig;
    logic [3:0]            s_dig;
    logic signed [4:0]     t_x;
    logic                  borrow_d;
    logic [3:0]            digit_d;

    function automatic logic has_bad(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Shared digit datapath: SUB uses a_i - b_i, NEG uses 0 - r_i.
    // t ranges -10..9, so the 4-bit wrap of t+10 is the corrected digit.
    always_comb begin
        pos   = 4 * int'(idx_q);
        m_dig = 4'd0;
        s_dig = 4'd0;
        if (state_q == ST_NEG) begin
            s_dig = res_q[pos +: 4];
        end else begin
            m_dig = a_q[pos +: 4];
            s_dig = b_q[pos +: 4];
        end
        t_x      = $signed({1'b0, m_dig}) - $signed({1'b0, s_dig}) - $signed({4'b0, br_q});
        borrow_d = t_x[4];
        digit_d  = borrow_d ? (t_x[3:0] + 4'd10) : t_x[3:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            idx_q      <= '0;
            br_q       <= 1'b0;
            neg_pend_q <= 1'b0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            diff_q     <= '0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q        <= a_i;
                        b_q        <= b_i;
                        br_q       <= bin_i;
                        idx_q      <= '0;
                        res_q      <= '0;
                        neg_pend_q <= 1'b0;
                        diff_q     <= '0;
                        neg_q      <= 1'b0;
                        err_q      <= 1'b0;
                        if (has_bad(a_i) || has_bad(b_i)) begin
                            err_pend_q <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            err_pend_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= ST_SUB;
                        end
                    end
                end
                ST_SUB: begin
                    res_q[pos +: 4] <= digit_d;
                    br_q            <= borrow_d;
                    if (idx_q == LAST_IDX) begin
                        idx_q <= '0;
                        if (borrow_d) begin
                            br_q       <= 1'b0;
                            neg_pend_q <= 1'b1;
                            state_q    <= ST_NEG;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                ST_NEG: begin
                    res_q[pos +: 4] <= digit_d;
                    br_q            <= borrow_d;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    diff_q  <= res_q;
                    neg_q   <= neg_pend_q;
                    err_q   <= err_pend_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign neg_o  = neg_q;
    assign err_o  = err_q;

endmodule
